activation_feeder: RTL and testbench

ACTIVATION_FEEDER -- requirements
Module: activation_feeder

---
 rtl/tpu_pkg.sv | 16 +
 rtl/feed_skew.sv | 23 ++
 rtl/activation_feeder.sv | 137 +++++++++++++
 tb/tb_activation_feeder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the TPU activation path.
package tpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N      = 2;

  // Last step index of a feed; a 2x2 skewed feed occupies steps 0..2.
  localparam logic [1:0] STEP_LAST = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/feed_skew.sv
// One-cycle delay stage for a systolic row input, with synchronous clear.
module feed_skew #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Delay register: cleared asynchronously by reset, synchronously by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/activation_feeder.sv
// Stages a 2x2 activation matrix and feeds it skewed into a systolic array:
// row 0 carries A00, A01; row 1 carries A10, A11 one cycle later.
module activation_feeder #(
  parameter int unsigned DATA_W = tpu_pkg::DATA_W,
  parameter int unsigned N      = tpu_pkg::N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic [DATA_W-1:0] a_out_0,
  output logic [DATA_W-1:0] a_out_1,
  output logic              valid_out,
  output logic              busy,
  output logic              done
);
  import tpu_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        step;
  logic [1:0]        step_nxt;
  logic [DATA_W-1:0] buffer [N*N];
  logic [DATA_W-1:0] row0_nxt;
  logic [DATA_W-1:0] row1_pre;
  logic              wr_fire;
  logic              skew_clear;

  // Writes land only while idle, and a coincident start takes priority.
  assign wr_fire    = (state == IDLE) && wr_en && !start;
  assign skew_clear = (state != FEED);

  // State and step registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // Next-state logic: IDLE -> FEED (3 steps) -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FEED;
          step_nxt  = '0;
        end
      end
      FEED: begin
        if (step == STEP_LAST) begin
          state_nxt = DONE;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 2'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  // Staging buffer, preserved across feeds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N*N; i++) begin
        buffer[i] <= '0;
      end
    end else if (wr_fire) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  // Row 0 value for the upcoming cycle, chosen from the next step so the
  // registered output lines up with the state it describes.
  always_comb begin
    row0_nxt = '0;
    if (state_nxt == FEED) begin
      case (step_nxt)
        2'd0:    row0_nxt = buffer[0];
        2'd1:    row0_nxt = buffer[1];
        default: row0_nxt = '0;
      endcase
    end
  end

  // Unskewed row 1 stream from the current step; feed_skew delays it by one
  // cycle so A10 appears at step 1 and A11 at step 2.
  always_comb begin
    row1_pre = '0;
    if (state == FEED) begin
      case (step)
        2'd0:    row1_pre = buffer[2];
        2'd1:    row1_pre = buffer[3];
        default: row1_pre = '0;
      endcase
    end
  end

  feed_skew #(
    .DATA_W(DATA_W)
  ) u_row1_skew (
    .clk  (clk),
    .reset(reset),
    .clear(skew_clear),
    .d    (row1_pre),
    .q    (a_out_1)
  );

  // Registered row 0 data and status flags, derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out_0   <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      a_out_0   <= row0_nxt;
      valid_out <= (state_nxt == FEED);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_activation_feeder.sv
// Randomized self-checking bench for activation_feeder against a matrix model.
module tb_activation_feeder;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [DW-1:0] a_out_0;
  logic [DW-1:0] a_out_1;
  logic          valid_out;
  logic          busy;
  logic          done;

  int checks;
  int passes;

  // Reference matrix, row-major: A00, A01, A10, A11.
  logic [DW-1:0] mbuf [4];

  activation_feeder #(
    .DATA_W(DW),
    .N     (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .a_out_0  (a_out_0),
    .a_out_1  (a_out_1),
    .valid_out(valid_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic write_elem(input logic [1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    mbuf[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One full feed with outputs compared each cycle against the skewed matrix
  // expected from the model. Optional disturbances: a write colliding with
  // start, a write+start during step 1, and a start during the done cycle.
  task automatic run_feed(input string name, input bit collide_wr,
                          input bit inject_mid, input bit start_in_done);
    logic [DW-1:0] e0 [3];
    logic [DW-1:0] e1 [3];
    e0[0] = mbuf[0]; e0[1] = mbuf[1]; e0[2] = '0;
    e1[0] = '0;      e1[1] = mbuf[2]; e1[2] = mbuf[3];

    @(negedge clk);
    checks++;
    if ({busy, valid_out, done, a_out_0, a_out_1} !== {3'b000, {2*DW{1'b0}}})
      $display("FAIL %s_idle_pre: got busy=%b valid=%b done=%b a0=%0d a1=%0d required all 0",
               name, busy, valid_out, done, a_out_0, a_out_1);
    else passes++;
    start = 1'b1;
    if (collide_wr) begin
      wr_en   = 1'b1;
      wr_addr = 2'd3;
      wr_data = DW'(7);
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;

    for (int s = 0; s < 3; s++) begin
      if (s == 2) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      checks++;
      if (a_out_0 !== e0[s] || a_out_1 !== e1[s] || valid_out !== 1'b1 ||
          busy !== 1'b1 || done !== 1'b0)
        $display("FAIL %s_step%0d: got a0=%0d a1=%0d valid=%b busy=%b done=%b required a0=%0d a1=%0d valid=1 busy=1 done=0",
                 name, s, a_out_0, a_out_1, valid_out, busy, done, e0[s], e1[s]);
      else passes++;
      if (s == 1 && inject_mid) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = DW'(9);
      end
      @(negedge clk);
    end

    checks++;
    if (done !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b1 ||
        a_out_0 !== '0 || a_out_1 !== '0)
      $display("FAIL %s_done: got done=%b valid=%b busy=%b a0=%0d a1=%0d required done=1 valid=0 busy=1 a0=0 a1=0",
               name, done, valid_out, busy, a_out_0, a_out_1);
    else passes++;
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0 ||
        a_out_0 !== '0 || a_out_1 !== '0)
      $display("FAIL %s_idle_post: got done=%b busy=%b valid=%b a0=%0d a1=%0d required all 0",
               name, done, busy, valid_out, a_out_0, a_out_1);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, valid_out, done, a_out_0, a_out_1} !== {3'b000, {2*DW{1'b0}}})
      $display("FAIL reset_state: got busy=%b valid=%b done=%b a0=%0d a1=%0d required all 0",
               busy, valid_out, done, a_out_0, a_out_1);
    else passes++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mbuf[i] = '0;
  endtask

  task automatic test_basic_feed();
    for (int i = 0; i < 4; i++) write_elem(2'(i), DW'(i + 1));
    run_feed("basic", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_replay();
    run_feed("replay", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_during_feed();
    run_feed("ignore_mid", 1'b0, 1'b1, 1'b1);
    run_feed("after_ignore", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midfeed();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_0 !== mbuf[1] || a_out_1 !== mbuf[2] || valid_out !== 1'b1)
      $display("FAIL midreset_step1: got a0=%0d a1=%0d valid=%b required a0=%0d a1=%0d valid=1",
               a_out_0, a_out_1, valid_out, mbuf[1], mbuf[2]);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, valid_out, done, a_out_0, a_out_1} !== {3'b000, {2*DW{1'b0}}})
      $display("FAIL midreset_async: got busy=%b valid=%b done=%b a0=%0d a1=%0d required all 0",
               busy, valid_out, done, a_out_0, a_out_1);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mbuf[i] = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0)
        $display("FAIL midreset_quiet%0d: got done=%b busy=%b valid=%b required 0 0 0",
                 c, done, busy, valid_out);
      else passes++;
    end
    run_feed("post_reset", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_element();
    write_elem(2'd0, DW'(5));
    write_elem(2'd1, DW'(6));
    write_elem(2'd2, DW'(0));
    write_elem(2'd3, DW'(8));
    run_feed("zero_a10", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_with_write();
    run_feed("start_collide", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++)
        write_elem(2'($urandom_range(0, 3)), DW'($urandom));
      run_feed($sformatf("rand%0d", it), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
    end
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    reset   = 1'b0;
    for (int i = 0; i < 4; i++) mbuf[i] = '0;

    test_reset();
    test_basic_feed();
    test_replay();
    test_ignore_during_feed();
    test_start_with_write();
    test_reset_midfeed();
    test_zero_element();
    test_random();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
